// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter that lets a DMA/loader
// port borrow the single data memory from the ARM core.
package dmem_arb_pkg;

  // Who currently owns the memory port.
  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_WAIT  = 4;
  localparam int DEF_BURST_LEN = 8;

  // Bits needed to hold the values 0..max_count without wrapping.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the three buses the arbiter touches: the core's data port, the
// DMA/loader beat port and the raw data-memory port.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // Core side: one access per cycle, retried by the core while stalled.
  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_stall;

  // DMA side: a beat is accepted on any cycle with dma_req && dma_gnt.
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_adr;
  logic [DATA_W-1:0] dma_wd;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  // Memory side: combinational read, write on the clock edge.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  // The arbiter itself.
  modport slave (
    input  cpu_valid, cpu_we, cpu_adr, cpu_wd,
    output cpu_rd, cpu_stall,
    input  dma_req, dma_we, dma_adr, dma_wd,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  // The surroundings: core, DMA engine and memory.
  modport master (
    output cpu_valid, cpu_we, cpu_adr, cpu_wd,
    input  cpu_rd, cpu_stall,
    output dma_req, dma_we, dma_adr, dma_wd,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the ARM core and a DMA/loader port.
// The core owns the memory by default. A DMA request is granted on the first
// idle core cycle, or forcibly once it has been blocked MAX_WAIT cycles. A
// grant lasts until the DMA drops its request or BURST_LEN beats have gone
// through, so the core is never locked out for more than BURST_LEN cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int WAIT_W = cnt_width(MAX_WAIT);
  localparam int BEAT_W = cnt_width(BURST_LEN);

  // Last blocked cycle before the DMA is forced in, and the last beat index.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST_LEN);

  arb_state_e        state_reg;
  arb_state_e        state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [BEAT_W-1:0] beat_cnt_next;
  logic              dma_rvalid_reg;
  logic [DATA_W-1:0] dma_rdata_reg;

  logic              beat_accept;
  logic              last_beat;
  logic              force_grant;

  logic [ADDR_W-1:0] mem_a_mux;
  logic [DATA_W-1:0] mem_wd_mux;
  logic              mem_we_mux;
  logic              dma_gnt_mux;
  logic              cpu_stall_mux;

  // A beat only counts while the DMA actually owns the port.
  assign beat_accept = (state_reg == S_DMA) && bus.dma_req;
  assign last_beat   = (beat_cnt_reg == BEAT_LAST);
  assign force_grant = (wait_cnt_reg == WAIT_LAST);

  // State and counter registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_CPU;
      wait_cnt_reg <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Ownership decisions: idle-cycle or starvation grant, burst-end release.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      S_CPU: begin
        if (bus.dma_req && (!bus.cpu_valid || force_grant)) begin
          state_next    = S_DMA;
          wait_cnt_next = '0;
          beat_cnt_next = '0;
        end else if (bus.dma_req) begin
          // Core is busy; the count is capped by the forced grant above.
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end else begin
          wait_cnt_next = '0;
        end
      end
      S_DMA: begin
        if (!bus.dma_req) begin
          // DMA went quiet: hand the port straight back.
          state_next    = S_CPU;
          wait_cnt_next = '0;
        end else begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (last_beat) begin
            // Burst quota used up: the core gets at least one cycle.
            state_next    = S_CPU;
            wait_cnt_next = '0;
          end
        end
      end
      default: begin
        state_next    = S_CPU;
        wait_cnt_next = '0;
        beat_cnt_next = '0;
      end
    endcase
  end

  // Port mux; reset forces the memory write, grant and stall low at once.
  always_comb begin
    mem_a_mux     = bus.cpu_adr;
    mem_wd_mux    = bus.cpu_wd;
    mem_we_mux    = bus.cpu_valid & bus.cpu_we;
    dma_gnt_mux   = 1'b0;
    cpu_stall_mux = 1'b0;
    if (state_reg == S_DMA) begin
      // Core store is dropped here; the stalled core retries it later.
      mem_a_mux     = bus.dma_adr;
      mem_wd_mux    = bus.dma_wd;
      mem_we_mux    = bus.dma_req & bus.dma_we;
      dma_gnt_mux   = 1'b1;
      cpu_stall_mux = bus.cpu_valid;
    end
    if (!reset) begin
      mem_we_mux    = 1'b0;
      dma_gnt_mux   = 1'b0;
      cpu_stall_mux = 1'b0;
    end
  end

  // Registered read return for DMA read beats; data holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_rvalid_reg <= 1'b0;
      dma_rdata_reg  <= '0;
    end else if (beat_accept && !bus.dma_we) begin
      dma_rvalid_reg <= 1'b1;
      dma_rdata_reg  <= bus.mem_rd;
    end else begin
      dma_rvalid_reg <= 1'b0;
    end
  end

  assign bus.mem_a      = mem_a_mux;
  assign bus.mem_wd     = mem_wd_mux;
  assign bus.mem_we     = mem_we_mux;
  assign bus.dma_gnt    = dma_gnt_mux;
  assign bus.cpu_stall  = cpu_stall_mux;
  assign bus.cpu_rd     = bus.mem_rd;
  assign bus.dma_rvalid = dma_rvalid_reg;
  assign bus.dma_rdata  = dma_rdata_reg;

  // Counters stay inside their documented ranges.
  a_wait_range : assert property (@(posedge clk) disable iff (!reset)
    wait_cnt_reg <= WAIT_LAST);
  a_beat_range : assert property (@(posedge clk) disable iff (!reset)
    beat_cnt_reg <= BEAT_MAX);
  // The core is only stalled while the DMA holds the port.
  a_stall_gnt  : assert property (@(posedge clk) disable iff (!reset)
    bus.cpu_stall |-> bus.dma_gnt);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes the expected mux outputs
// for each cycle and the expected DMA read returns into queues; a monitor on
// the falling edge pops and compares them against what the arbiter presents.
module tb_dmem_arbiter;

  typedef struct {
    logic        g;
    logic        s;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    string       tag;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_clear = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  exp_t mon_e;
  rd_t  mon_r;

  logic [31:0] mem [256];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .BURST_LEN(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:0]] <= bus.mem_wd;
    end
  end
  assign bus.mem_rd = mem[bus.mem_a[7:0]];

  // Monitor: one mux expectation per driven cycle, plus every read return.
  always @(negedge clk) begin
    if (reset) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (bus.dma_gnt !== mon_e.g || bus.cpu_stall !== mon_e.s || bus.mem_we !== mon_e.we ||
            bus.mem_a !== mon_e.a || bus.mem_wd !== mon_e.wd) begin
          errors++;
          $display("FAIL %s @%0d: got gnt=%0b stall=%0b we=%0b a=%h wd=%h, want gnt=%0b stall=%0b we=%0b a=%h wd=%h",
                   mon_e.tag, cyc, bus.dma_gnt, bus.cpu_stall, bus.mem_we, bus.mem_a, bus.mem_wd,
                   mon_e.g, mon_e.s, mon_e.we, mon_e.a, mon_e.wd);
        end
      end
      if (bus.dma_rvalid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected @%0d: got rvalid=1 rdata=%h, want rvalid=0", cyc, bus.dma_rdata);
        end else begin
          mon_r = rd_q.pop_front();
          if (bus.dma_rdata !== mon_r.data || cyc != mon_r.due) begin
            errors++;
            $display("FAIL rdata @%0d: got %h, want %h at cycle %0d", cyc, bus.dma_rdata, mon_r.data, mon_r.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus.cpu_valid = v;
    bus.cpu_we    = we;
    bus.cpu_adr   = a;
    bus.cpu_wd    = wd;
  endtask

  task automatic drive_dma(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus.dma_req = r;
    bus.dma_we  = we;
    bus.dma_adr = a;
    bus.dma_wd  = wd;
  endtask

  task automatic expect_cyc(input logic g, input logic s, input logic we,
                            input logic [31:0] a, input logic [31:0] wd, input string tag);
    exp_t e;
    e.g = g; e.s = s; e.we = we; e.a = a; e.wd = wd; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Read beat accepted this cycle: data must come back on the next one.
  task automatic expect_rd(input logic [31:0] data);
    rd_t r;
    r.data = data;
    r.due  = cyc + 1;
    rd_q.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    drive_cpu(0, 0, 32'h10, 32'h0);
    drive_dma(0, 0, 32'h0, 32'h0);
    tick();
    mem_clear = 1'b0;
    tick();

    // Reset held: core store requested but everything gated off.
    drive_cpu(1, 1, 32'h64, 32'h7);
    #1;
    chk("rst_gnt", {31'b0, bus.dma_gnt}, 32'h0);
    chk("rst_stall", {31'b0, bus.cpu_stall}, 32'h0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    chk("rst_rvalid", {31'b0, bus.dma_rvalid}, 32'h0);
    chk("rst_rdata", bus.dma_rdata, 32'h0);
    reset = 1'b1;
    expect_cyc(0, 0, 1, 32'h64, 32'h7, "cpu_store");
    tick();
    chk("mem_64", mem[8'h64], 32'h7);

    // Single DMA write beat with the core idle.
    drive_cpu(0, 0, 32'h10, 32'h0);
    drive_dma(1, 1, 32'h80, 32'hAB);
    expect_cyc(0, 0, 0, 32'h10, 32'h0, "wr_req");    tick();
    expect_cyc(1, 0, 1, 32'h80, 32'hAB, "wr_beat");  tick();
    drive_dma(0, 1, 32'h80, 32'hAB);
    expect_cyc(1, 0, 0, 32'h80, 32'hAB, "wr_drop");  tick();
    drive_dma(0, 0, 32'h0, 32'h0);
    expect_cyc(0, 0, 0, 32'h10, 32'h0, "wr_back");   tick();
    chk("mem_80", mem[8'h80], 32'hAB);

    // Single DMA read beat of the word just written.
    drive_dma(1, 0, 32'h80, 32'h0);
    expect_cyc(0, 0, 0, 32'h10, 32'h0, "rd_req");    tick();
    expect_cyc(1, 0, 0, 32'h80, 32'h0, "rd_beat");
    expect_rd(32'hAB);                               tick();
    drive_dma(0, 0, 32'h80, 32'h0);
    expect_cyc(1, 0, 0, 32'h80, 32'h0, "rd_drop");   tick();
    expect_cyc(0, 0, 0, 32'h10, 32'h0, "rd_back");   tick();

    // Busy core storing every cycle: forced grant after four blocked cycles.
    drive_cpu(1, 1, 32'h64, 32'h7);
    drive_dma(1, 1, 32'hA0, 32'h55);
    for (int k = 0; k < 4; k++) begin
      expect_cyc(0, 0, 1, 32'h64, 32'h7, "force_wait");
      tick();
    end
    expect_cyc(1, 1, 1, 32'hA0, 32'h55, "force_beat"); tick();
    drive_dma(0, 1, 32'hA0, 32'h55);
    expect_cyc(1, 1, 0, 32'hA0, 32'h55, "force_drop"); tick();
    expect_cyc(0, 0, 1, 32'h64, 32'h7, "force_back");  tick();
    chk("mem_A0", mem[8'hA0], 32'h55);

    // 20-cycle request against a loading core: two capped bursts (8 then 4).
    drive_cpu(1, 0, 32'h64, 32'h7);
    for (int i = 0; i < 20; i++) begin
      drive_dma(1, 1, 32'hC0 + i, 32'h100 + i);
      if ((i >= 4 && i <= 11) || i >= 16)
        expect_cyc(1, 1, 1, 32'hC0 + i, 32'h100 + i, "burst_dma");
      else
        expect_cyc(0, 0, 0, 32'h64, 32'h7, "burst_cpu");
      tick();
    end
    drive_dma(0, 1, 32'hD4, 32'h114);
    expect_cyc(1, 1, 0, 32'hD4, 32'h114, "burst_drop"); tick();
    drive_cpu(0, 0, 32'h10, 32'h0);
    drive_dma(0, 0, 32'h0, 32'h0);
    expect_cyc(0, 0, 0, 32'h10, 32'h0, "burst_back");   tick();
    chk("mem_C3", mem[8'hC3], 32'h0);
    chk("mem_C4", mem[8'hC4], 32'h104);
    chk("mem_CB", mem[8'hCB], 32'h10B);
    chk("mem_CC", mem[8'hCC], 32'h0);
    chk("mem_D0", mem[8'hD0], 32'h110);
    chk("mem_D3", mem[8'hD3], 32'h113);

    // Burst interrupted by reset during its third beat (write to 0x90).
    drive_cpu(1, 0, 32'h64, 32'h7);
    drive_dma(1, 1, 32'h88, 32'h21);
    for (int k = 0; k < 4; k++) begin
      expect_cyc(0, 0, 0, 32'h64, 32'h7, "abort_wait");
      tick();
    end
    expect_cyc(1, 1, 1, 32'h88, 32'h21, "abort_b1");  tick();
    drive_dma(1, 0, 32'h80, 32'h0);
    expect_cyc(1, 1, 0, 32'h80, 32'h0, "abort_b2");
    expect_rd(32'hAB);                                tick();
    drive_dma(1, 1, 32'h90, 32'h23);
    expect_cyc(1, 1, 1, 32'h90, 32'h23, "abort_b3");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_gnt", {31'b0, bus.dma_gnt}, 32'h0);
    chk("abort_stall", {31'b0, bus.cpu_stall}, 32'h0);
    chk("abort_mem_we", {31'b0, bus.mem_we}, 32'h0);
    chk("abort_rvalid", {31'b0, bus.dma_rvalid}, 32'h0);
    tick();
    chk("mem_90", mem[8'h90], 32'h0);
    chk("mem_88", mem[8'h88], 32'h21);
    chk("abort_gnt_held", {31'b0, bus.dma_gnt}, 32'h0);
    drive_cpu(0, 0, 32'h10, 32'h0);
    drive_dma(0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    expect_cyc(0, 0, 0, 32'h10, 32'h0, "abort_cpu"); tick();
    expect_cyc(0, 0, 0, 32'h10, 32'h0, "idle");      tick();

    chk("queues_drained", exp_q.size() + rd_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
